// File: rtl/simproc_loader_pkg.sv
// simproc_loader_pkg: shared state type and memory geometry for the simproc program loader.
// No ports; imported by simproc_loader and simproc_mem_mux.
package simproc_loader_pkg;
    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 8;
    localparam int MEM_DEPTH = 256;
    typedef enum logic [2:0] {IDLE, LOAD, SETPC, RUN, FINISH} state_t;
endpackage

// File: rtl/simproc_mem_mux.sv
// simproc_mem_mux: selects which side owns the shared program-memory write port.
// Ports: core_sel picks core_* (core running) over loader_*; mem_* go to the memory.
module simproc_mem_mux
    import simproc_loader_pkg::*;
(
    input  logic              core_sel,
    input  logic [ADDR_W-1:0] loader_addr,
    input  logic [DATA_W-1:0] loader_din,
    input  logic              loader_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_din,
    input  logic              core_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_we
);
    always_comb begin
        mem_addr = core_sel ? core_addr : loader_addr;
        mem_din  = core_sel ? core_din : loader_din;
        mem_we   = core_sel ? core_we : loader_we;
    end
endmodule

// File: rtl/simproc_loader.sv
// simproc_loader: host byte-stream program loader and run controller for simproc.
// Ports: in_valid/in_data/in_last/in_ready host stream (first byte = base address);
//        core_mem_* core memory port in, mem_* shared memory port out;
//        pc_set_val/pc_set_wr/run/halt/done simproc control; busy/finished/err_*/
//        load_count/cycle_count/instr_count status. rst is asynchronous, active-low.
// Optional: define SIMPROC_LOADER_CHECKSUM_EN to treat the in_last byte as a checksum
//           (adds the err_checksum output).
module simproc_loader
    import simproc_loader_pkg::*;
#(
    parameter int MAX_CYCLES = 1024,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] core_mem_addr,
    input  logic [DATA_W-1:0] core_mem_din,
    input  logic              core_mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_we,
    output logic [ADDR_W-1:0] pc_set_val,
    output logic              pc_set_wr,
    output logic              run,
    input  logic              halt,
    input  logic              done,
    output logic              busy,
    output logic              finished,
    output logic              err_timeout,
    output logic              err_overflow,
`ifdef SIMPROC_LOADER_CHECKSUM_EN
    output logic              err_checksum,
`endif
    output logic [8:0]        load_count,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  instr_count
);
    localparam logic [8:0]       FULL = 9'(MEM_DEPTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_CYCLES - 1);
    state_t state, state_nx;
    logic [ADDR_W-1:0] base, wr_ptr;
    logic xfer, payload, load_we, chk_bad, timeout;
    assign xfer = in_valid && in_ready;
`ifdef SIMPROC_LOADER_CHECKSUM_EN
    // Running sum of base and every payload byte; the closing checksum byte must bring it to 0.
    logic [DATA_W-1:0] sum;
    assign payload = !in_last;
    assign chk_bad = DATA_W'(sum + in_data) != '0;
`else
    assign payload = 1'b1;
    assign chk_bad = 1'b0;
`endif
    // Bytes past the 256th are accepted but never written.
    assign load_we = state == LOAD && xfer && payload && load_count != FULL;
    assign timeout = cycle_count == LAST;
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = xfer ? (in_last ? SETPC : LOAD) : IDLE;
            LOAD:    state_nx = xfer && in_last ? (chk_bad ? FINISH : SETPC) : LOAD;
            SETPC:   state_nx = RUN;
            RUN:     state_nx = halt || timeout ? FINISH : RUN;
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_comb begin
        in_ready   = state == IDLE || state == LOAD;
        pc_set_wr  = state == SETPC;
        pc_set_val = pc_set_wr ? base : '0;
        run        = state == RUN;
        finished   = state == FINISH;
        busy       = state != IDLE;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base         <= '0;
            wr_ptr       <= '0;
            load_count   <= '0;
            cycle_count  <= '0;
            instr_count  <= '0;
            err_timeout  <= 1'b0;
            err_overflow <= 1'b0;
`ifdef SIMPROC_LOADER_CHECKSUM_EN
            sum          <= '0;
            err_checksum <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (xfer) begin
                    base         <= in_data;
                    wr_ptr       <= in_data;
                    load_count   <= '0;
                    cycle_count  <= '0;
                    instr_count  <= '0;
                    err_timeout  <= 1'b0;
                    err_overflow <= 1'b0;
`ifdef SIMPROC_LOADER_CHECKSUM_EN
                    sum          <= in_data;
                    err_checksum <= 1'b0;
`endif
                end
                LOAD: if (xfer) begin
                    if (load_we) begin
                        wr_ptr     <= wr_ptr + 8'd1;
                        load_count <= load_count + 9'd1;
                    end
                    if (payload && load_count == FULL) err_overflow <= 1'b1;
`ifdef SIMPROC_LOADER_CHECKSUM_EN
                    if (payload) sum <= sum + in_data;
                    if (in_last && chk_bad) err_checksum <= 1'b1;
`endif
                end
                SETPC: begin
                    cycle_count <= '0;
                    instr_count <= '0;
                end
                RUN: begin
                    cycle_count <= cycle_count + CNT_W'(cycle_count != '1);
                    if (done) instr_count <= instr_count + CNT_W'(instr_count != '1);
                    // halt in the final budget cycle wins over the timeout
                    if (!halt && timeout) err_timeout <= 1'b1;
                end
                default: ;
            endcase
        end
    end
    simproc_mem_mux u_mux (
        .core_sel    (state == RUN),
        .loader_addr (wr_ptr),
        .loader_din  (in_data),
        .loader_we   (load_we),
        .core_addr   (core_mem_addr),
        .core_din    (core_mem_din),
        .core_we     (core_mem_we),
        .mem_addr    (mem_addr),
        .mem_din     (mem_din),
        .mem_we      (mem_we)
    );
endmodule

// File: doc/simproc_loader.md
Name: simproc_loader

Overview:
Host-facing program loader and memory-port arbiter that sits directly upstream of simproc. It accepts a byte stream with a valid/ready handshake and writes the stream into the shared 256x8 program memory. It then loads the processor PC through pc_set_val/pc_set_wr and holds run until simproc asserts halt or a cycle budget expires. While the core runs, the core owns the memory write port. At all other times the loader owns it.

Parameters:
MAX_CYCLES, 1024, run-phase cycle budget before timeout abort (must be ≥1)
CNT_W, 16, width of cycle_count and instr_count

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  host byte valid
in_data  in  8  host byte; first byte of a packet = base address, rest = payload
in_last  in  1  marks final byte of packet
in_ready  out  1  loader accepts byte this cycle (valid&&ready = transfer)
core_mem_addr  in  8  simproc mem_addr
core_mem_din  in  8  simproc mem_din
core_mem_we  in  1  simproc mem_we
mem_addr  out  8  to memory
mem_din  out  8  to memory
mem_we  out  1  to memory
pc_set_val  out  8  to simproc
pc_set_wr  out  1  to simproc
run  out  1  to simproc
halt  in  1  simproc halted
done  in  1  simproc instruction-complete pulse
busy  out  1  packet in progress or core running
finished  out  1  one-cycle pulse at end of run, error or not
err_timeout  out  1  sticky; budget expired
err_overflow  out  1  sticky; payload exceeded 256 bytes
load_count  out  9  payload bytes written in last packet (0..256)
cycle_count  out  CNT_W  cycles spent in RUN
instr_count  out  CNT_W  done pulses counted in RUN

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs 0, except mem_* which drive the loader mux with addr=0 and we=0. Counters 0. Errors cleared.
- FSM states: IDLE, LOAD, SETPC, RUN, FINISH.
- IDLE: in_ready=1.
  - On a transfer, latch base=in_data, wr_ptr=base, clear load_count and errors, go to LOAD.
  - If in_last is set on the base byte, go straight to SETPC with load_count=0.
- LOAD: in_ready=1.
  - Each transfer drives mem_we=1, mem_addr=wr_ptr, mem_din=in_data combinationally in that same cycle. Then wr_ptr+1 (mod 256) and load_count+1.
  - A transfer with in_last goes to SETPC.
  - If load_count==256 when a further byte arrives, that byte is dropped (mem_we=0) and err_overflow is set. Bytes keep being accepted until in_last.
- SETPC: in_ready=0. pc_set_val=base and pc_set_wr=1 for exactly 1 cycle. Clear cycle_count and instr_count. Go to RUN.
- RUN: in_ready=0. run=1. The memory mux selects core_mem_* (combinational pass-through).
  - cycle_count+1 each cycle (saturating). instr_count+1 on each done (saturating).
  - halt=1 → FINISH. This is checked before the timeout.
  - cycle_count==MAX_CYCLES-1 without halt → set err_timeout, go to FINISH.
  - Budget: run is high for MAX_CYCLES cycles at most.
- FINISH: run=0, finished=1 for 1 cycle, then IDLE. Counters and errors hold until the next packet starts.
- busy=1 in every state except IDLE.
- Core write attempts outside RUN are ignored (mem_we forced to loader value).
- Reset mid-operation: run and pc_set_wr drop immediately (async). Memory contents are not touched.

Optional Feature:
SIMPROC_LOADER_CHECKSUM_EN.
- Defined: the byte carrying in_last is an 8-bit checksum, not payload, and is not written. Required: the sum mod 256 of base+payload+checksum == 0.
  - Mismatch sets sticky err_checksum (extra 1-bit output port) and goes to FINISH, skipping SETPC/RUN.
- Undefined: the last byte is payload. There is no err_checksum port.

Decomposition:
- Package simproc_loader_pkg holds:
  - state enum typedef (IDLE, LOAD, SETPC, RUN, FINISH)
  - ADDR_W=8 and DATA_W=8
  - MEM_DEPTH=256
- One natural sub-module: simproc_mem_mux, the combinational owner select between loader and core memory ports, keyed on state==RUN.
- The FSM and counters stay in the top module.

Test Plan:
- Packet {0x00, 0x90, 0x44, 0x47, 0xA8, 0x06, 0xDA(last)}:
  - mem[0..5] written in 6 consecutive cycles.
  - load_count=6.
  - pc_set_wr pulses once with pc_set_val=0x00, then run=1.
- Same load with a core model asserting halt after 12 cycles and 6 done pulses:
  - run lasts 12 cycles, finished pulses once.
  - cycle_count=12, instr_count=6, no errors.
- MAX_CYCLES=16, halt never asserted:
  - run is high exactly 16 cycles.
  - err_timeout=1, finished pulses, busy returns to 0.
- Base 0xFE and 3 payload bytes:
  - writes land at 0xFE, 0xFF, 0x00 (wrap).
  - pc_set_val=0xFE.
- 257 payload bytes: mem_we is high for only 256 of them, err_overflow=1, load_count=256.
- Assert rst low mid-RUN:
  - run and all status outputs go to 0 before the next clock edge.
  - a new packet after release loads and runs normally.
- With SIMPROC_LOADER_CHECKSUM_EN, packet {0x10, 0x01, 0x02, 0xED}:
  - Checksum passes; RUN entered, err_checksum=0.
- Same packet with a bad checksum byte 0xEE:
  - err_checksum=1, run never asserts.
